// File: rtl/rej_sampler_ntt_if.sv
// Purpose: rate-block handshake between the SHAKE128 sponge (master) and the sampler (slave).
// Latency: none, this is wiring only.
// Backpressure: a block moves only on a clock edge where blk_valid and blk_ready are both high.
// Ports: blk_valid (sponge has a block), blk_data (R-bit block, bit 0 squeezed first),
//        blk_ready (sampler can take a block).
interface rej_sampler_ntt_if #(
  parameter int R = 1344
);
  logic         blk_valid;
  logic         blk_ready;
  logic [R-1:0] blk_data;

  modport master (output blk_valid, output blk_data, input blk_ready);
  modport slave  (input blk_valid, input blk_data, output blk_ready);
endinterface

// File: rtl/rej_sampler_ntt.sv
// Purpose: Kyber rejection sampler (Parse/SampleNTT). It turns SHAKE128 rate blocks into one
//          N-coefficient polynomial with every coefficient in [0,Q).
// Latency: the first coefficient is written 1 cycle after a block transfer. A block takes
//          R/24 cycles, one 24-bit triple per cycle.
// Backpressure: blk_ready is high only in WAIT_BLK. A block offered at any other time stays
//               with the sponge until the sampler is ready.
// Ports: clk, rst (async active-low), enable (start/restart in IDLE or DONE),
//        blk (slave side of the rate-block handshake),
//        poly_out (coeff k at [12k+11:12k]), coef_count (coefficients accepted),
//        done (level: finished or aborted), err (level: block budget ran out).
module rej_sampler_ntt #(
  parameter int R        = 1344,
  parameter int N        = 256,
  parameter int Q        = 3329,
  parameter int MAX_BLKS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  rej_sampler_ntt_if.slave           blk,
  output logic [N*12-1:0]            poly_out,
  output logic [$clog2(N+1)-1:0]     coef_count,
  output logic                       done,
  output logic                       err
);

  localparam int TRIPLES = R / 24;
  localparam int TW      = (TRIPLES > 1) ? $clog2(TRIPLES) : 1;
  localparam int BOW     = $clog2(R);
  localparam int PW      = $clog2(N * 12);
  localparam int IW      = $clog2(N);
  localparam int CW      = $clog2(N + 1);
  localparam int KW      = $clog2(MAX_BLKS + 1);

  localparam logic [11:0]   Q_C    = 12'(Q);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [TW-1:0] T_LAST = TW'(TRIPLES - 1);
  localparam logic [KW-1:0] MAX_C  = KW'(MAX_BLKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [R-1:0]    buf_q, buf_d;
  logic [TW-1:0]   t_q, t_d;
  logic [KW-1:0]   blk_cnt_q, blk_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*12-1:0] poly_q, poly_d;
  logic            err_q, err_d;

  logic [BOW-1:0]  boff;
  logic [23:0]     triple;
  logic [11:0]     d1, d2;
  logic [PW-1:0]   woff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      t_q       <= '0;
      blk_cnt_q <= '0;
      cnt_q     <= '0;
      poly_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      t_q       <= t_d;
      blk_cnt_q <= blk_cnt_d;
      cnt_q     <= cnt_d;
      poly_q    <= poly_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    t_d       = t_q;
    blk_cnt_d = blk_cnt_q;
    cnt_d     = cnt_q;
    poly_d    = poly_q;
    err_d     = err_q;
    woff      = '0;

    // The current triple is split into two little-endian 12-bit candidates.
    // This is the same as Kyber's byte formulas on b0,b1,b2.
    boff   = BOW'(t_q) * BOW'(24);
    triple = buf_q[boff +: 24];
    d1     = triple[11:0];
    d2     = triple[23:12];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (enable) begin
          poly_d    = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
          blk_cnt_d = '0;
          state_d   = S_WAIT_BLK;
        end
      end

      S_WAIT_BLK: begin
        if (blk.blk_valid) begin
          buf_d     = blk.blk_data;
          t_d       = '0;
          blk_cnt_d = blk_cnt_q + KW'(1);
          state_d   = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        // cnt_d is a running index. When d1 is accepted, d2 goes to the slot after it,
        // and both are held to the N limit.
        if ((d1 < Q_C) && (cnt_d < N_C)) begin
          woff               = PW'(cnt_d[IW-1:0]) * PW'(12);
          poly_d[woff +: 12] = d1;
          cnt_d              = cnt_d + CW'(1);
        end
        if ((d2 < Q_C) && (cnt_d < N_C)) begin
          woff               = PW'(cnt_d[IW-1:0]) * PW'(12);
          poly_d[woff +: 12] = d2;
          cnt_d              = cnt_d + CW'(1);
        end

        // A full polynomial wins over end of block, so the rest of the buffer is dropped.
        if (cnt_d == N_C) begin
          state_d = S_DONE;
        end else if (t_q == T_LAST) begin
          if (blk_cnt_q < MAX_C) begin
            state_d = S_WAIT_BLK;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign blk.blk_ready = (state_q == S_WAIT_BLK);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign poly_out      = poly_q;
  assign coef_count    = cnt_q;

endmodule
